pll_lock_sequencer: RTL and testbench

Sequences PLL bring-up on the free-running oscillator clock. It asserts PLL reset, waits for a stable lock, and only then releases the system reset to the processing logic. It also retries on lock timeout, re-sequences on lock loss or a user relock request, and reports status to the LED/processor logic. It sits in the top level between the PLL primitive's reset/locked pins and the system-reset net.

---
 rtl/pll_lock_sequencer.sv | 167 ++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: holds the PLL in reset, waits for a stable lock, then releases system reset.
// Optional lock-loss event counter is built when PLL_LOCK_LOSS_COUNT_EN is defined.
module pll_lock_sequencer #(
  parameter int pRstHoldCycles    = 100,
  parameter int pLockStableCycles = 1024,
  parameter int pLockTimeout      = 65536,
  parameter int pMaxRetry         = 3
) (
  input  logic       iSysClk,
  input  logic       iSysRst,
  input  logic       iPllLocked,
  input  logic       iRelockReq,
  input  logic       iClrStatus,
  output logic       oPllRst,
  output logic       oSysRst,
  output logic       oRunning,
  output logic       oFail,
  output logic       oLockLost,
  output logic [3:0] oRetryCnt,
  output logic [1:0] oState,
  output logic [7:0] oLockLossCnt
);

  localparam int HOLD_W = $clog2(pRstHoldCycles + 1);
  localparam int STAB_W = $clog2(pLockStableCycles + 1);
  localparam int TOUT_W = $clog2(pLockTimeout + 1);

  typedef enum logic [1:0] {
    S_HOLD      = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_RUN       = 2'd2,
    S_FAIL      = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_lk_meta;
  logic              r_lk_s;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [STAB_W-1:0] r_stable_cnt;
  logic [TOUT_W-1:0] r_tout_cnt;
  logic [3:0]        r_retry_cnt;
  logic              r_pll_rst;
  logic              r_sys_rst;
  logic              r_running;
  logic              r_fail;
  logic              r_lock_lost;
  logic              w_loss_evt;

  // Lock dropping while running; this takes priority over a same-cycle relock request.
  assign w_loss_evt = (r_state == S_RUN) && !r_lk_s;

  always_ff @(posedge iSysClk) begin
    if (iSysRst) begin
      r_lk_meta <= 1'b0;
      r_lk_s    <= 1'b0;
    end else begin
      r_lk_meta <= iPllLocked;
      r_lk_s    <= r_lk_meta;
    end
  end

  always_ff @(posedge iSysClk) begin
    if (iSysRst) begin
      r_state      <= S_HOLD;
      r_hold_cnt   <= '0;
      r_stable_cnt <= '0;
      r_tout_cnt   <= '0;
      r_retry_cnt  <= '0;
      r_pll_rst    <= 1'b1;
      r_sys_rst    <= 1'b1;
      r_running    <= 1'b0;
      r_fail       <= 1'b0;
    end else begin
      case (r_state)
        S_HOLD: begin
          if (r_hold_cnt == HOLD_W'(pRstHoldCycles - 1)) begin
            r_state      <= S_WAIT_LOCK;
            r_hold_cnt   <= '0;
            r_stable_cnt <= '0;
            r_tout_cnt   <= '0;
            r_pll_rst    <= 1'b0;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          if (r_lk_s && (r_stable_cnt == STAB_W'(pLockStableCycles - 1))) begin
            r_state   <= S_RUN;
            r_sys_rst <= 1'b0;
            r_running <= 1'b1;
          end else begin
            r_stable_cnt <= r_lk_s ? r_stable_cnt + 1'b1 : '0;
            if (r_tout_cnt == TOUT_W'(pLockTimeout - 1)) begin
              r_pll_rst  <= 1'b1;
              r_hold_cnt <= '0;
              if (r_retry_cnt < 4'(pMaxRetry)) begin
                r_state     <= S_HOLD;
                r_retry_cnt <= r_retry_cnt + 1'b1;
              end else begin
                r_state <= S_FAIL;
                r_fail  <= 1'b1;
              end
            end else begin
              r_tout_cnt <= r_tout_cnt + 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_loss_evt || iRelockReq) begin
            r_state     <= S_HOLD;
            r_hold_cnt  <= '0;
            r_retry_cnt <= '0;
            r_pll_rst   <= 1'b1;
            r_sys_rst   <= 1'b1;
            r_running   <= 1'b0;
          end
        end
        S_FAIL: begin
          if (iRelockReq) begin
            r_state     <= S_HOLD;
            r_hold_cnt  <= '0;
            r_retry_cnt <= '0;
            r_fail      <= 1'b0;
          end
        end
        default: r_state <= S_HOLD;
      endcase
    end
  end

  always_ff @(posedge iSysClk) begin
    if (iSysRst) begin
      r_lock_lost <= 1'b0;
    end else if (w_loss_evt) begin
      r_lock_lost <= 1'b1;
    end else if (iClrStatus) begin
      r_lock_lost <= 1'b0;
    end
  end

`ifdef PLL_LOCK_LOSS_COUNT_EN
  logic [7:0] r_loss_cnt;

  always_ff @(posedge iSysClk) begin
    if (iSysRst) begin
      r_loss_cnt <= '0;
    end else if (w_loss_evt) begin
      if (r_loss_cnt != 8'hFF) r_loss_cnt <= r_loss_cnt + 1'b1;
    end else if (iClrStatus) begin
      r_loss_cnt <= '0;
    end
  end

  assign oLockLossCnt = r_loss_cnt;
`else
  assign oLockLossCnt = 8'h00;
`endif

  assign oPllRst   = r_pll_rst;
  assign oSysRst   = r_sys_rst;
  assign oRunning  = r_running;
  assign oFail     = r_fail;
  assign oLockLost = r_lock_lost;
  assign oRetryCnt = r_retry_cnt;
  assign oState    = r_state;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer (hold 4, stable 8, timeout 32, 2 retries).
module tb_pll_lock_sequencer;

  logic       iSysClk;
  logic       iSysRst;
  logic       iPllLocked;
  logic       iRelockReq;
  logic       iClrStatus;
  logic       oPllRst;
  logic       oSysRst;
  logic       oRunning;
  logic       oFail;
  logic       oLockLost;
  logic [3:0] oRetryCnt;
  logic [1:0] oState;
  logic [7:0] oLockLossCnt;

  int checks = 0;
  int errors = 0;

  pll_lock_sequencer #(
    .pRstHoldCycles   (4),
    .pLockStableCycles(8),
    .pLockTimeout     (32),
    .pMaxRetry        (2)
  ) dut (
    .iSysClk     (iSysClk),
    .iSysRst     (iSysRst),
    .iPllLocked  (iPllLocked),
    .iRelockReq  (iRelockReq),
    .iClrStatus  (iClrStatus),
    .oPllRst     (oPllRst),
    .oSysRst     (oSysRst),
    .oRunning    (oRunning),
    .oFail       (oFail),
    .oLockLost   (oLockLost),
    .oRetryCnt   (oRetryCnt),
    .oState      (oState),
    .oLockLossCnt(oLockLossCnt)
  );

  initial iSysClk = 1'b0;
  always #5 iSysClk = ~iSysClk;

  // Expected lock-loss count after n loss events since the last clear.
  function automatic int exp_lc(input int n);
`ifdef PLL_LOCK_LOSS_COUNT_EN
    return (n > 255) ? 255 : n;
`else
    return 0;
`endif
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge iSysClk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic lock);
    iPllLocked = lock;
    iRelockReq = 1'b0;
    iClrStatus = 1'b0;
    iSysRst    = 1'b1;
    step(3);
    iSysRst = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, input string tag);
    int n = 0;
    while (oState !== s && n < budget) begin
      step(1);
      n++;
    end
    chk(tag, 32'(oState), 32'(s));
  endtask

  // Pin low for one cycle; the FSM sees it on the third edge afterwards.
  task automatic glitch_lock(input logic relock, input logic clr);
    iPllLocked = 1'b0;
    step(1);
    iPllLocked = 1'b1;
    step(1);
    iRelockReq = relock;
    iClrStatus = clr;
    step(1);
    iRelockReq = 1'b0;
    iClrStatus = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset(1'b1);
    iSysRst = 1'b1;
    step(1);
    chk("rst_state", 32'(oState), 0);
    chk("rst_pllrst", 32'(oPllRst), 1);
    chk("rst_sysrst", 32'(oSysRst), 1);
    chk("rst_running", 32'(oRunning), 0);
    chk("rst_fail", 32'(oFail), 0);
    chk("rst_lost", 32'(oLockLost), 0);
    chk("rst_retry", 32'(oRetryCnt), 0);
    chk("rst_losscnt", 32'(oLockLossCnt), 0);

    // 1: constant lock
    iSysRst = 1'b0;
    step(3);
    chk("t1_hold3_pllrst", 32'(oPllRst), 1);
    chk("t1_hold3_state", 32'(oState), 0);
    step(1);
    chk("t1_wait_pllrst", 32'(oPllRst), 0);
    chk("t1_wait_state", 32'(oState), 1);
    step(7);
    chk("t1_w7_sysrst", 32'(oSysRst), 1);
    step(1);
    chk("t1_w8_sysrst", 32'(oSysRst), 0);
    chk("t1_w8_state", 32'(oState), 2);
    chk("t1_w8_running", 32'(oRunning), 1);

    // 2: glitch at stable count 5 restarts the stable counter
    do_reset(1'b1);
    step(7);
    iPllLocked = 1'b0;
    step(1);
    iPllLocked = 1'b1;
    step(4);
    chk("t2_w8_state", 32'(oState), 1);
    step(5);
    chk("t2_w13_state", 32'(oState), 1);
    step(1);
    chk("t2_w14_state", 32'(oState), 2);
    chk("t2_retry", 32'(oRetryCnt), 0);

    // 3: never locks -> retries then FAIL
    do_reset(1'b0);
    step(35);
    chk("t3_w31_state", 32'(oState), 1);
    chk("t3_w31_retry", 32'(oRetryCnt), 0);
    step(1);
    chk("t3_to1_state", 32'(oState), 0);
    chk("t3_to1_retry", 32'(oRetryCnt), 1);
    chk("t3_to1_pllrst", 32'(oPllRst), 1);
    step(36);
    chk("t3_to2_state", 32'(oState), 0);
    chk("t3_to2_retry", 32'(oRetryCnt), 2);
    step(35);
    chk("t3_w3_state", 32'(oState), 1);
    step(1);
    chk("t3_fail_state", 32'(oState), 3);
    chk("t3_fail_flag", 32'(oFail), 1);
    chk("t3_fail_pllrst", 32'(oPllRst), 1);
    chk("t3_fail_sysrst", 32'(oSysRst), 1);
    step(5);
    chk("t3_fail_stay", 32'(oState), 3);
    iRelockReq = 1'b1;
    step(1);
    iRelockReq = 1'b0;
    chk("t3_relock_state", 32'(oState), 0);
    chk("t3_relock_retry", 32'(oRetryCnt), 0);
    chk("t3_relock_fail", 32'(oFail), 0);

    // 4: lock loss in RUN, sticky flag, clear, set-wins
    do_reset(1'b1);
    step(12);
    chk("t4_run", 32'(oState), 2);
    iPllLocked = 1'b0;
    step(1);
    iPllLocked = 1'b1;
    step(1);
    chk("t4_e2_state", 32'(oState), 2);
    step(1);
    chk("t4_e3_state", 32'(oState), 0);
    chk("t4_e3_sysrst", 32'(oSysRst), 1);
    chk("t4_e3_lost", 32'(oLockLost), 1);
    chk("t4_e3_running", 32'(oRunning), 0);
    wait_state(2'd2, 40, "t4_relock_run");
    step(3);
    chk("t4_lost_sticky", 32'(oLockLost), 1);
    chk("t4_losscnt", 32'(oLockLossCnt), 32'(exp_lc(1)));
    iClrStatus = 1'b1;
    step(1);
    iClrStatus = 1'b0;
    chk("t4_clr_lost", 32'(oLockLost), 0);
    chk("t4_clr_losscnt", 32'(oLockLossCnt), 0);
    glitch_lock(1'b0, 1'b1);
    chk("t4_setwins_lost", 32'(oLockLost), 1);

    // 5: relock request in RUN, then relock coinciding with loss
    do_reset(1'b1);
    step(12);
    chk("t5_run", 32'(oState), 2);
    iRelockReq = 1'b1;
    step(1);
    iRelockReq = 1'b0;
    chk("t5_req_state", 32'(oState), 0);
    chk("t5_req_pllrst", 32'(oPllRst), 1);
    chk("t5_req_lost", 32'(oLockLost), 0);
    step(3);
    chk("t5_h4_state", 32'(oState), 0);
    chk("t5_h4_pllrst", 32'(oPllRst), 1);
    step(1);
    chk("t5_wait_state", 32'(oState), 1);
    chk("t5_req_losscnt", 32'(oLockLossCnt), 0);
    wait_state(2'd2, 40, "t5_rerun");
    glitch_lock(1'b1, 1'b0);
    chk("t5_both_state", 32'(oState), 0);
    chk("t5_both_lost", 32'(oLockLost), 1);
    chk("t5_both_losscnt", 32'(oLockLossCnt), 32'(exp_lc(1)));

    // 6: 300 lock-loss events
    do_reset(1'b1);
    step(12);
    for (int i = 0; i < 300; i++) begin
      glitch_lock(1'b0, 1'b0);
      wait_state(2'd2, 40, "t6_rerun");
    end
    chk("t6_losscnt_sat", 32'(oLockLossCnt), 32'(exp_lc(300)));
    iClrStatus = 1'b1;
    step(1);
    iClrStatus = 1'b0;
    chk("t6_losscnt_clr", 32'(oLockLossCnt), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
